data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit word locations; it must be a power of two and at least 2.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the data and address width; only the value 32 is supported.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning the number of extra wait states per access; the range is 0 to 15.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port req: input, 1 bit, access request; sampled only while the block is idle.
REQ-007 Port we: input, 1 bit, 1 = store, 0 = load.
REQ-008 Port size: input, 2 bits, access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 Port sign: input, 1 bit, load extension: 1 = sign-extend, 0 = zero-extend.
REQ-010 Port adr: input, WIDTH bits, byte address.
REQ-011 Port din: input, WIDTH bits, store data, right-aligned.
REQ-012 Port dout: output, WIDTH bits, registered load result, right-aligned and extended.
REQ-013 Port busy: output, 1 bit, high while an access is in flight.
REQ-014 Port ready: output, 1 bit, one-cycle pulse on access completion.
REQ-015 Port err: output, 1 bit, one-cycle pulse together with ready when the completing access faulted.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-017 IDLE: when req=1, SHALL capture we, size, sign, adr and din and move to WAIT if WAIT_CYCLES>0, otherwise to DONE; when req=0, SHALL stay in IDLE.
REQ-018 WAIT: SHALL count WAIT_CYCLES clocks with a 4-bit counter, then move to DONE.
REQ-019 DONE: SHALL assert ready (and err if the access faulted) for exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be high in WAIT and DONE and low in IDLE.
REQ-021 Latency: ready SHALL be asserted exactly WAIT_CYCLES+1 cycles after the accepting edge, so back-to-back accesses achieve one access per WAIT_CYCLES+2 cycles.
REQ-022 req SHALL be ignored while busy=1; no queuing.
REQ-023 The memory write and the dout update SHALL occur on the edge that enters DONE, using only the captured values.
REQ-024 Word index SHALL be adr[log2(DEPTH)+1:2]; upper address bits are ignored, so the address wraps modulo 4*DEPTH.
REQ-025 Byte lanes SHALL be little-endian: the byte at adr[1:0]=k occupies bits [8k+7:8k].
REQ-026 A store SHALL write only the addressed lanes: byte = din[7:0] into lane adr[1:0]; half = din[15:0] into lanes adr[1:0] and adr[1:0]+1; word = all four lanes.
REQ-027 Byte and half loads SHALL be extended to 32 bits as selected by sign; word loads SHALL be returned unchanged.
REQ-028 A fault SHALL be any of: half with adr[0]=1; word with adr[1:0]!=0; size=11.
REQ-029 On a fault, the block SHALL perform no memory write, leave dout unchanged, and pulse err with ready.
REQ-030 dout SHALL hold its value between completions; a store SHALL NOT alter dout.
REQ-031 A load issued immediately after a store to the same address SHALL return the newly stored data.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, wait counter=0, dout=0, busy=0, ready=0 and err=0.
REQ-033 rst asserted mid-access SHALL abort the access and discard any pending write.
REQ-034 Memory contents SHALL NOT be cleared by reset and SHALL be undefined at power-up.

Structure
REQ-035 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-036 SHALL instantiate one sub-module, dmem_array: DEPTH x 32-bit storage with a 4-bit byte-enable synchronous write port and a combinational read port; the FSM, alignment logic and extension logic SHALL live in data_ram.

Verification
REQ-037 With WAIT_CYCLES=0: store word 0xDEADBEEF at 0x10, then load word from 0x10 -> ready exactly 1 cycle after each accept; dout=0xDEADBEEF; err=0.
REQ-038 Store byte 0x80 at 0x13, then load byte from 0x13 with sign=1 -> dout=0xFFFFFF80; with sign=0 -> dout=0x00000080; load word from 0x10 -> 0x80ADBEEF.
REQ-039 Store half at 0x11 -> err=1 with ready; a subsequent load word from 0x10 returns the prior value unchanged; dout unchanged by the faulted access.
REQ-040 With WAIT_CYCLES=3: accept at cycle 0 -> busy cycles 1-4, ready only at cycle 4; req pulses during cycles 1-4 are ignored.
REQ-041 With WAIT_CYCLES=3: accept store 0x12345678 at 0x20 where memory holds 0x0; assert rst in cycle 2 -> ready never pulses; a later load from 0x20 returns 0x0; outputs are 0 during reset.
REQ-042 With DEPTH=1024: store word 0xA5A5A5A5 at 0x1000, then load from 0x0 -> dout=0xA5A5A5A5 (address wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data RAM block: access-size
//               encodings, the access FSM state type and the misalignment
//               fault predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size encodings carried on the size port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // An access faults when it is misaligned for its size, or when the
    // reserved size code is used.
    function automatic logic access_fault(input logic [1:0] sz, input logic [1:0] lo);
        logic f;
        case (sz)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = lo[0];
            SZ_WORD: f = |lo;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x 32-bit word storage with a byte-enabled synchronous
//               write port and a combinational read port sharing one address.
//               Contents are not reset.
// Ports       : clk      - clock
//               i_addr   - word index (read and write)
//               i_be     - per-byte write enables, lane k = bits [8k+7:8k]
//               i_wdata  - write data, already placed in its byte lanes
//               o_rdata  - combinational read of the addressed word
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [3:0]               i_be,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_be[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_ram
// Description : Byte-addressed data memory with byte/half/word loads and
//               stores, optional fixed wait states, sign/zero extension of
//               narrow loads and misalignment fault reporting.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               req                - access request (sampled only when idle)
//               we                 - 1 = store, 0 = load
//               size               - 00 byte, 01 half, 10 word, 11 reserved
//               sign               - narrow load sign-extension select
//               adr, din           - byte address, right-aligned store data
//               dout               - registered, extended load result
//               busy, ready, err   - in-flight flag, completion pulse, fault
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WIDTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             sign,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             ready,
    output logic             err
);

    localparam int         c_aw        = $clog2(DEPTH);
    localparam logic [3:0] c_wait_last = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    if (WIDTH != 32) begin : g_width_check
        $error("data_ram: WIDTH must be 32");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("data_ram: DEPTH must be a power of two and at least 2");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_wait_check
        $error("data_ram: WAIT_CYCLES must be 0..15");
    end

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_sign;
    logic [c_aw+1:0]  r_adr;
    logic [31:0]      r_din;
    logic [31:0]      r_dout;
    logic             r_busy;
    logic             r_ready;
    logic             r_err;

    // Access attributes in effect for the completing access. With no wait
    // states the completing edge is also the accepting edge, so the values
    // being captured are used directly; otherwise the captured copies are.
    logic             w_idle;
    logic             w_we;
    logic [1:0]       w_size;
    logic             w_sign;
    logic [c_aw+1:0]  w_adr;
    logic [31:0]      w_din;
    logic             w_fault;
    logic             w_enter_done;
    logic [3:0]       w_be;
    logic [3:0]       w_lane_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load;
    logic             w_unused_adr;

    assign w_idle = (r_state == IDLE);
    assign w_we   = w_idle ? we   : r_we;
    assign w_size = w_idle ? size : r_size;
    assign w_sign = w_idle ? sign : r_sign;
    assign w_adr  = w_idle ? adr[c_aw+1:0] : r_adr;
    assign w_din  = w_idle ? din  : r_din;

    // Address bits above the word index are deliberately ignored (wrap).
    assign w_unused_adr = &{1'b0, adr[WIDTH-1:c_aw+2]};

    assign w_fault = access_fault(w_size, w_adr[1:0]);

    assign w_enter_done = (w_idle && req && (WAIT_CYCLES == 0)) ||
                          ((r_state == WAIT) && (r_cnt == c_wait_last));

    // Store lane placement: replicate narrow data across the word and let
    // the byte enables pick the addressed lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_din;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_adr[1:0];
                w_wdata = {4{w_din[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_adr[1:0];
                w_wdata = {2{w_din[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
            end
            default: begin
                w_be    = 4'b0000;
            end
        endcase
    end

    // Writes happen only on the completing edge of a non-faulting store, and
    // never while reset is held (an aborted access must not reach memory).
    assign w_lane_be = (w_enter_done && w_we && !w_fault && !rst) ? w_be : 4'b0000;

    dmem_array #(
        .DEPTH   (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_adr[c_aw+1:2]),
        .i_be    (w_lane_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Load alignment: bring the addressed lane(s) down to bit 0, then extend.
    assign w_shifted = w_rdata >> {w_adr[1:0], 3'b000};

    always_comb begin
        w_load = w_rdata;
        case (w_size)
            SZ_BYTE: w_load = {{24{w_sign & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: w_load = {{16{w_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sign  <= 1'b0;
            r_adr   <= '0;
            r_din   <= 32'd0;
            r_dout  <= 32'd0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we   <= we;
                        r_size <= size;
                        r_sign <= sign;
                        r_adr  <= adr[c_aw+1:0];
                        r_din  <= din;
                        r_busy <= 1'b1;
                        r_cnt  <= 4'd0;
                        r_state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == c_wait_last) begin
                        r_cnt   <= 4'd0;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase

            // Completion: pulse ready/err for the DONE cycle; only a good
            // load updates dout.
            if (w_enter_done) begin
                r_ready <= 1'b1;
                r_err   <= w_fault;
                if (!w_fault && !w_we) begin
                    r_dout <= w_load;
                end
            end
        end
    end

    assign dout  = r_dout;
    assign busy  = r_busy;
    assign ready = r_ready;
    assign err   = r_err;

endmodule : data_ram
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram
// Description : Self-checking bench for data_ram. Two instances: one with no
//               wait states, one with three. A reference memory model
//               predicts each completion; predictions are queued when a
//               request is driven and popped when ready pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [1:0]  size  [2];
    logic        sign  [2];
    logic [31:0] adr   [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic        busy  [2];
    logic        ready [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          d;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mmem [int];
    logic [31:0] mdout [2];

    data_ram #(.DEPTH(1024), .WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
        .sign(sign[0]), .adr(adr[0]), .din(din[0]), .dout(dout[0]),
        .busy(busy[0]), .ready(ready[0]), .err(err[0])
    );

    data_ram #(.DEPTH(1024), .WIDTH(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
        .sign(sign[1]), .adr(adr[1]), .din(din[1]), .dout(dout[1]),
        .busy(busy[1]), .ready(ready[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Reference model: apply one access, push the predicted completion.
    function automatic void model_push(input int d, input logic w, input logic [1:0] sz,
                                       input logic sg, input logic [31:0] a,
                                       input logic [31:0] dn);
        int          key;
        int          lane;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        logic        fault;
        exp_t        e;
        key   = d * 4096 + int'((a >> 2) & 32'h3FF);
        lane  = int'(a[1:0]);
        word  = mmem.exists(key) ? mmem[key] : 32'h0;
        fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (!fault) begin
            if (w) begin
                if (sz == 2'b00)      word[lane*8 +: 8]  = dn[7:0];
                else if (sz == 2'b01) word[lane*8 +: 16] = dn[15:0];
                else                  word = dn;
                mmem[key] = word;
            end else begin
                b = word[lane*8 +: 8];
                h = word[lane*8 +: 16];
                if (sz == 2'b00)      mdout[d] = sg ? {{24{b[7]}}, b} : {24'h0, b};
                else if (sz == 2'b01) mdout[d] = sg ? {{16{h[15]}}, h} : {16'h0, h};
                else                  mdout[d] = word;
            end
        end
        e.d    = d;
        e.dout = mdout[d];
        e.err  = fault;
        sbq.push_back(e);
    endfunction

    task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] dn);
        req[d] = 1'b1; we[d] = w; size[d] = sz; sign[d] = sg; adr[d] = a; din[d] = dn;
    endtask

    // One complete access: drive, wait for ready, check latency and result.
    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] dn);
        exp_t e;
        int   n;
        @(negedge clk);
        drive(d, w, sz, sg, a, dn);
        model_push(d, w, sz, sg, a, dn);
        @(negedge clk);
        req[d] = 1'b0;
        n = 1;
        while (ready[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        checks++;
        if (ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout dut%0d: ready=%b after %0d cycles, required 1", d, ready[d], n);
        end else begin
            checks++;
            if (n != lat(d)) begin
                errors++;
                $display("FAIL latency dut%0d: got %0d cycles, required %0d", d, n, lat(d));
            end
            checks++;
            if (dout[d] !== e.dout) begin
                errors++;
                $display("FAIL dout dut%0d adr=%h: got %h, required %h", d, a, dout[d], e.dout);
            end
            checks++;
            if (err[d] !== e.err) begin
                errors++;
                $display("FAIL err dut%0d adr=%h: got %b, required %b", d, a, err[d], e.err);
            end
            checks++;
            if (busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL busy_done dut%0d: got %b, required 1", d, busy[d]);
            end
        end
        @(negedge clk);
        checks++;
        if (ready[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) begin
            errors++;
            $display("FAIL pulse_end dut%0d: ready=%b busy=%b err=%b, required 0 0 0",
                     d, ready[d], busy[d], err[d]);
        end
    endtask

    task automatic check_dout(input int d, input string nm, input logic [31:0] exp);
        checks++;
        if (dout[d] !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, required %h", nm, d, dout[d], exp);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'b00;
            sign[d] = 1'b0; adr[d] = 32'h0; din[d] = 32'h0; mdout[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dout[d] !== 32'h0 || busy[d] !== 1'b0 || ready[d] !== 1'b0 || err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: dout=%h busy=%b ready=%b err=%b, required all 0",
                         d, dout[d], busy[d], ready[d], err[d]);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
    endtask

    task automatic test_word();
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_dout(0, "word_load", 32'hDEADBEEF);
    endtask

    task automatic test_byte_ext();
        access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
        access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check_dout(0, "byte_sext", 32'hFFFFFF80);
        access(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check_dout(0, "byte_zext", 32'h00000080);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_dout(0, "byte_merge", 32'h80ADBEEF);
    endtask

    task automatic test_fault();
        access(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000CAFE);
        check_dout(0, "fault_dout_hold", 32'h80ADBEEF);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_dout(0, "fault_no_write", 32'h80ADBEEF);
        access(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        access(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11223344);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_half();
        access(0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h01020304);
        access(0, 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF8001);
        access(0, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        check_dout(0, "half_sext", 32'hFFFF8001);
        access(0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
        access(0, 1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check_dout(0, "half_merge", 32'h80010304);
    endtask

    task automatic test_wrap();
        access(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A5A5A5);
        access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check_dout(0, "addr_wrap", 32'hA5A5A5A5);
    endtask

    task automatic test_wait_latency();
        exp_t e;
        access(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h22222222);
        @(negedge clk);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        model_push(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            // Stray requests while busy must be ignored
            drive(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h11111111);
            req[1] = (c % 2 == 1) ? 1'b1 : 1'b0;
            checks++;
            if (busy[1] !== 1'b1 || ready[1] !== (c == 4)) begin
                errors++;
                $display("FAIL wait_cycle%0d: busy=%b ready=%b, required 1 %b", c, busy[1], ready[1], (c == 4));
            end
            if (c == 4) begin
                req[1] = 1'b0;
                e = sbq.pop_front();
                checks++;
                if (dout[1] !== e.dout) begin
                    errors++;
                    $display("FAIL wait_dout: got %h, required %h", dout[1], e.dout);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0 || ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle5: busy=%b ready=%b, required 0 0", busy[1], ready[1]);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        check_dout(1, "ignored_req_no_write", 32'h22222222);
    endtask

    task automatic test_reset_abort();
        int seen;
        access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000);
        @(negedge clk);
        drive(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        mdout[1] = 32'h0;
        #1;
        checks++;
        if (dout[1] !== 32'h0 || busy[1] !== 1'b0 || ready[1] !== 1'b0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_midaccess: dout=%h busy=%b ready=%b err=%b, required all 0",
                     dout[1], busy[1], ready[1], err[1]);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready[1] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_ready: saw %0d ready pulses, required 0", seen);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check_dout(1, "abort_no_write", 32'h00000000);
    endtask

    task automatic test_back_to_back(input int d, input logic [31:0] a);
        exp_t e;
        int   c;
        int   got;
        int   period;
        period = lat(d) + 1;
        for (int k = 0; k < 3; k++) model_push(d, 1'b0, 2'b10, 1'b0, a, 32'h0);
        @(negedge clk);
        drive(d, 1'b0, 2'b10, 1'b0, a, 32'h0);
        c = 0;
        got = 0;
        while (got < 3 && c < 60) begin
            @(negedge clk);
            c++;
            if (ready[d] === 1'b1) begin
                got++;
                e = sbq.pop_front();
                checks++;
                if (c != lat(d) + (got - 1) * period || dout[d] !== e.dout) begin
                    errors++;
                    $display("FAIL b2b dut%0d #%0d: cycle %0d dout %h, required cycle %0d dout %h",
                             d, got, c, dout[d], lat(d) + (got - 1) * period, e.dout);
                end
                if (got == 3) req[d] = 1'b0;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL b2b_count dut%0d: got %0d completions, required 3", d, got);
            while (sbq.size() > 0) void'(sbq.pop_front());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_ext();
        test_fault();
        test_half();
        test_wrap();
        test_wait_latency();
        test_reset_abort();
        test_back_to_back(0, 32'h10);
        test_back_to_back(1, 32'h44);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_ram
`default_nettype wire
